// File: rtl/tester_pkg.sv
// Shared types and default constants for the harness run controller.
package tester_pkg;

  // Run controller phases, in the order a run walks through them.
  typedef enum logic [2:0] {
    StIdle,
    StAssert,
    StSettle,
    StRun,
    StDone
  } state_e;

  // Sticky run outcome; a single register keeps pass and fail exclusive.
  typedef enum logic [1:0] {
    VerdictNone,
    VerdictPass,
    VerdictFail
  } verdict_e;

  localparam int unsigned RESET_CYCLES_DEF = 4;
  localparam int unsigned TIMEOUT_DEF      = 1024;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear (priority over enable) that sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_d, count_q;

  // Next count: clear wins, otherwise step unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dut_reset_sequencer.sv
// Run controller for the injection harnesses: holds harness reset, releases it, watches the
// per-instance done flags against a timeout and ends each run with a finish pulse and verdict.
module dut_reset_sequencer
  import tester_pkg::*;
#(
  parameter int unsigned NUM_DUTS       = 2,
  parameter int unsigned RESET_CYCLES   = RESET_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_DUTS-1:0] dut_done,
  output logic                dut_reset,
  output logic                busy,
  output logic                finish,
  output logic                pass,
  output logic                fail,
  output logic [CNT_W-1:0]    cycle_count
);

  localparam logic [CNT_W-1:0]    RstLast     = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]    TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_DUTS-1:0] AllDone     = '1;

  state_e              state_q;
  verdict_e            verdict_q;
  logic [NUM_DUTS-1:0] mask_q;
  logic                dut_reset_q;
  logic                busy_q;
  logic                finish_q;

  logic [CNT_W-1:0] rst_cnt;
  logic [CNT_W-1:0] run_cnt;

  logic launch;
  logic rst_last;
  logic all_done;
  logic timed_out;

  // Decode of the current phase used by the FSM and both counters.
  always_comb begin
    launch    = start && ((state_q == StIdle) || (state_q == StDone));
    rst_last  = (state_q == StAssert) && (rst_cnt == RstLast);
    // Include this cycle's flags so a done pulse on the exit cycle still counts.
    all_done  = (state_q == StRun) && ((mask_q | dut_done) == AllDone);
    timed_out = (state_q == StRun) && (run_cnt == TimeoutLast);
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_rst_counter (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clear_i (launch),
    .en_i    (state_q == StAssert),
    .count_o (rst_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_run_counter (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clear_i (launch),
    .en_i    (state_q == StRun),
    .count_o (run_cnt)
  );

  // Run FSM with registered harness reset, busy, finish, done mask and verdict.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      verdict_q   <= VerdictNone;
      mask_q      <= '0;
      dut_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q     <= StAssert;
            verdict_q   <= VerdictNone;
            mask_q      <= '0;
            dut_reset_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        StAssert: begin
          if (rst_last) begin
            state_q     <= StSettle;
            dut_reset_q <= 1'b0;
          end
        end
        StSettle: begin
          state_q <= StRun;
        end
        StRun: begin
          mask_q <= mask_q | dut_done;
          if (all_done || timed_out) begin
            state_q     <= StDone;
            verdict_q   <= all_done ? VerdictPass : VerdictFail;
            dut_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            finish_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign dut_reset   = dut_reset_q;
  assign busy        = busy_q;
  assign finish      = finish_q;
  assign pass        = (verdict_q == VerdictPass);
  assign fail        = (verdict_q == VerdictFail);
  assign cycle_count = run_cnt;

endmodule

// File: tb/tb_dut_reset_sequencer.sv
// Self-checking bench for dut_reset_sequencer: directed runs followed by randomized done patterns,
// each checked cycle by cycle against outcomes computed from the run rules.
module tb_dut_reset_sequencer;

  localparam int NumDuts = 2;
  localparam int R       = 4;
  localparam int Tmo     = 16;
  localparam int CntW    = 16;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic [NumDuts-1:0] dut_done;
  logic               dut_reset;
  logic               busy;
  logic               finish;
  logic               pass;
  logic               fail;
  logic [CntW-1:0]    cycle_count;

  int unsigned total  = 0;
  int unsigned passes = 0;
  int unsigned fails  = 0;
  int          run_id = 0;

  dut_reset_sequencer #(
    .NUM_DUTS       (NumDuts),
    .RESET_CYCLES   (R),
    .TIMEOUT_CYCLES (Tmo),
    .CNT_W          (CntW)
  ) u_dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dut_done    (dut_done),
    .dut_reset   (dut_reset),
    .busy        (busy),
    .finish      (finish),
    .pass        (pass),
    .fail        (fail),
    .cycle_count (cycle_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where, input int e_rst, input int e_busy,
                           input int e_fin, input int e_pass, input int e_fail, input int e_cnt);
    check({where, " dut_reset"}, 32'(dut_reset), 32'(e_rst));
    check({where, " busy"}, 32'(busy), 32'(e_busy));
    check({where, " finish"}, 32'(finish), 32'(e_fin));
    check({where, " pass"}, 32'(pass), 32'(e_pass));
    check({where, " fail"}, 32'(fail), 32'(e_fail));
    check({where, " cycle_count"}, 32'(cycle_count), 32'(e_cnt));
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // One run launched in the current cycle (cycle 0). DUT i raises done for len_i cycles starting
  // on 1-based RUN cycle t0_i (0 = never). The outcome is worked out first: the run passes iff
  // every instance shows done within the first Tmo RUN cycles, and it lasts until the latest
  // instance first reports (or Tmo cycles on a fail).
  task automatic run_seq(input int t0a, input int t0b, input int la, input int lb,
                         input bit glitch);
    int  t0 [NumDuts];
    int  ln [NumDuts];
    int  e;
    int  d;
    int  k;
    int  e_cnt;
    bit  pass_exp;
    logic [NumDuts-1:0] done_v;
    string where;
    t0[0] = t0a;
    t0[1] = t0b;
    ln[0] = la;
    ln[1] = lb;
    run_id++;
    pass_exp = 1'b1;
    e = 0;
    for (int i = 0; i < NumDuts; i++) begin
      if (t0[i] < 1 || t0[i] > Tmo) pass_exp = 1'b0;
      else if (t0[i] > e) e = t0[i];
    end
    if (!pass_exp) e = Tmo;
    d = R + 2 + e;  // cycle on which DONE is entered

    start    = 1'b1;
    dut_done = NumDuts'($urandom);
    for (int n = 1; n <= d + 1; n++) begin
      next_cycle();
      start  = (n < d) ? 1'($urandom_range(0, 1)) : 1'b0;
      done_v = '0;
      if (n <= R + 1) begin
        if (glitch) done_v = NumDuts'($urandom);
      end else if (n < d) begin
        k = n - R - 1;
        for (int i = 0; i < NumDuts; i++) begin
          if (t0[i] != 0 && k >= t0[i] && k < t0[i] + ln[i]) done_v[i] = 1'b1;
        end
      end
      dut_done = done_v;
      e_cnt = (n >= R + 2) ? (((n - R - 2) < e) ? (n - R - 2) : e) : 0;
      where = $sformatf("run%0d c%0d", run_id, n);
      check_all(where, (n <= R || n >= d) ? 1 : 0, (n < d) ? 1 : 0, (n == d) ? 1 : 0,
                (n >= d && pass_exp) ? 1 : 0, (n >= d && !pass_exp) ? 1 : 0, e_cnt);
    end
    start    = 1'b0;
    dut_done = '0;
  endtask

  initial begin
    int t0a;
    int t0b;
    int la;
    int lb;
    reset    = 1'b0;
    start    = 1'b0;
    dut_done = '0;

    // Power-on reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check_all("por", 1, 0, 0, 0, 0, 0);
    end
    reset = 1'b1;
    next_cycle();
    check_all("idle", 1, 0, 0, 0, 0, 0);

    // Nominal: both done from RUN cycle 10.
    run_seq(10, 10, 100, 100, 1'b0);
    // Staggered single-cycle pulses, with noise on done during reset hold and settle.
    run_seq(3, 7, 1, 1, 1'b1);
    // Timeout: only instance 0 ever reports.
    run_seq(5, 0, 100, 0, 1'b0);
    // Full done lands on the timeout cycle.
    run_seq(2, Tmo, 100, 1, 1'b1);

    // Reset while sitting in DONE with a pass verdict.
    reset = 1'b0;
    #1;
    check_all("rst_in_done", 1, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    next_cycle();
    check_all("idle2", 1, 0, 0, 0, 0, 0);

    // Reset asynchronously on RUN cycle 5, then a clean run.
    start = 1'b1;
    for (int n = 1; n <= R + 6; n++) begin
      next_cycle();
      start    = 1'b0;
      dut_done = '0;
    end
    check("mid_run cycle_count", 32'(cycle_count), 32'd4);
    check("mid_run busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_all("mid_rst", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      check_all("mid_rst_hold", 1, 0, 0, 0, 0, 0);
    end
    reset = 1'b1;
    next_cycle();
    check_all("idle3", 1, 0, 0, 0, 0, 0);
    run_seq(6, 1, 2, 100, 1'b0);

    // Randomized runs, each relaunched straight from DONE.
    for (int r = 0; r < 12; r++) begin
      t0a = $urandom_range(0, Tmo + 3);
      t0b = $urandom_range(0, Tmo + 3);
      la  = ($urandom_range(0, 1) == 1) ? 100 : $urandom_range(1, 3);
      lb  = ($urandom_range(0, 1) == 1) ? 100 : $urandom_range(1, 3);
      run_seq(t0a, t0b, la, lb, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
